// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 tick scheduler slice.
//   state_t            : step-sequencer FSM encoding (IDLE/PENDING/PAUSED)
//   TIMER_W            : width of the DT/ST countdown registers
//   BACKLOG_MAX_DEFAULT: default depth of the owed-step backlog
package chip8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam int unsigned TIMER_W             = 8;
  localparam int unsigned BACKLOG_MAX_DEFAULT = 3;

endpackage

// File: rtl/chip8_countdown_reg.sv
// Loadable saturating down-counter used for the CHIP-8 DT and ST registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load wdata (wins over tick)
//   tick       : decrement request (ignored unless enable)
//   enable     : gates tick (low while the core is paused)
//   wdata      : load value
//   q          : current value; holds at 0 instead of wrapping
module chip8_countdown_reg
  import chip8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               tick,
  input  logic               enable,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] q
);

  logic [TIMER_W-1:0] q_next;

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = wdata;
    end else if (tick && enable && (q != '0)) begin
      q_next = q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/chip8_tick_scheduler.sv
// Turns timer_cpu_tick pulses into counted CPU step requests (req/ack
// handshake with a bounded backlog) and owns the DT/ST countdown registers.
//   timer_cpu_tick  : instruction-rate pulse, queued as a step request
//   timer_60hz_tick : decrements DT/ST when not paused
//   pause           : freezes stepping and DT/ST decrement
//   cpu_step_req    : at least one step is owed (registered)
//   cpu_step_ack    : CPU consumed one step (honoured only while req is high)
//   dt_we/st_we     : load wdata into DT/ST (priority over decrement)
//   dt_q/st_q       : current DT/ST values
//   sound_on        : registered, high whenever ST is non-zero
//   tick_overrun    : saturating count of ticks dropped at a full backlog
module chip8_tick_scheduler
  import chip8_pkg::*;
#(
  parameter int unsigned BACKLOG_MAX = BACKLOG_MAX_DEFAULT,
  parameter int unsigned OVR_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               timer_cpu_tick,
  input  logic               timer_60hz_tick,
  input  logic               pause,
  output logic               cpu_step_req,
  input  logic               cpu_step_ack,
  input  logic               dt_we,
  input  logic               st_we,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] dt_q,
  output logic [TIMER_W-1:0] st_q,
  output logic               sound_on,
  output logic [OVR_W-1:0]   tick_overrun
);

  localparam logic [2:0] BL_MAX = 3'(BACKLOG_MAX);

  state_t     state, state_next;
  logic [2:0] backlog, backlog_next;
  logic       accept, full, inc, dec, drop;
  logic       sound_next;

  // Ticks are only considered while pause is low; an ack counts only
  // against a request the CPU could actually see.
  always_comb begin
    accept       = timer_cpu_tick && !pause;
    dec          = cpu_step_ack && cpu_step_req;
    full         = (backlog == BL_MAX);
    inc          = accept && (!full || dec);
    drop         = accept && full && !dec;
    backlog_next = backlog + {2'b00, inc} - {2'b00, dec};
    if (pause) begin
      state_next = ST_PAUSED;
    end else if (backlog_next != 3'd0) begin
      state_next = ST_PENDING;
    end else begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      backlog      <= 3'd0;
      cpu_step_req <= 1'b0;
      tick_overrun <= '0;
    end else begin
      state        <= state_next;
      backlog      <= backlog_next;
      cpu_step_req <= (state_next == ST_PENDING);
      if (drop && (tick_overrun != '1)) begin
        tick_overrun <= tick_overrun + 1'b1;
      end
    end
  end

  chip8_countdown_reg u_dt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dt_we),
    .tick   (timer_60hz_tick),
    .enable (!pause),
    .wdata  (wdata),
    .q      (dt_q)
  );

  chip8_countdown_reg u_st (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (st_we),
    .tick   (timer_60hz_tick),
    .enable (!pause),
    .wdata  (wdata),
    .q      (st_q)
  );

  // Mirrors the ST next-value rule so sound_on flips on the same edge
  // that st_q reaches or leaves zero.
  always_comb begin
    if (st_we) begin
      sound_next = (wdata != '0);
    end else if (timer_60hz_tick && !pause && (st_q == 8'd1)) begin
      sound_next = 1'b0;
    end else begin
      sound_next = (st_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sound_on <= 1'b0;
    end else begin
      sound_on <= sound_next;
    end
  end

endmodule

// File: tb/tb_chip8_tick_scheduler.sv
module tb_chip8_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timer_cpu_tick = 1'b0;
  logic       timer_60hz_tick = 1'b0;
  logic       pause = 1'b0;
  logic       cpu_step_req;
  logic       cpu_step_ack = 1'b0;
  logic       dt_we = 1'b0;
  logic       st_we = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] dt_q;
  logic [7:0] st_q;
  logic       sound_on;
  logic [7:0] tick_overrun;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  chip8_tick_scheduler #(.BACKLOG_MAX(3), .OVR_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .timer_cpu_tick  (timer_cpu_tick),
    .timer_60hz_tick (timer_60hz_tick),
    .pause           (pause),
    .cpu_step_req    (cpu_step_req),
    .cpu_step_ack    (cpu_step_ack),
    .dt_we           (dt_we),
    .st_we           (st_we),
    .wdata           (wdata),
    .dt_q            (dt_q),
    .st_q            (st_q),
    .sound_on        (sound_on),
    .tick_overrun    (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle with the given pulse inputs (pause is a level and is
  // left as set by the caller); outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic tick, input logic t60, input logic ack,
                     input logic dwe, input logic swe, input logic [7:0] d);
    timer_cpu_tick  = tick;
    timer_60hz_tick = t60;
    cpu_step_ack    = ack;
    dt_we           = dwe;
    st_we           = swe;
    wdata           = d;
    @(posedge clk);
    #1;
    timer_cpu_tick  = 1'b0;
    timer_60hz_tick = 1'b0;
    cpu_step_ack    = 1'b0;
    dt_we           = 1'b0;
    st_we           = 1'b0;
    wdata           = 8'h00;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_req", 32'(cpu_step_req), 32'd0);
    check("rst_dt", 32'(dt_q), 32'd0);
    check("rst_st", 32'(st_q), 32'd0);
    check("rst_sound", 32'(sound_on), 32'd0);
    check("rst_ovr", 32'(tick_overrun), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00);

    // Single tick: req one cycle later, one ack releases it
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("t1_req_up", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("t1_req_down", 32'(cpu_step_req), 32'd0);
    // Stray ack with req low must not underflow the backlog
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("stray_ack_req", 32'(cpu_step_req), 32'd0);
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("post_stray_req", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("post_stray_clear", 32'(cpu_step_req), 32'd0);

    // Five ticks without ack: backlog saturates at 3, two dropped
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 8'h00);
    check("ovf_req", 32'(cpu_step_req), 32'd1);
    check("ovf_count", 32'(tick_overrun), 32'd2);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("ovf_ack1", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("ovf_ack2", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("ovf_ack3", 32'(cpu_step_req), 32'd0);

    // Tick and ack together at backlog 1: backlog stays 1
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 1, 0, 0, 8'h00);
    check("same_cyc_req", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("same_cyc_clear", 32'(cpu_step_req), 32'd0);

    // DT=3, ST=2, then four 60 Hz ticks
    cyc(0, 0, 0, 1, 0, 8'd3);
    check("dt_load", 32'(dt_q), 32'd3);
    cyc(0, 0, 0, 0, 1, 8'd2);
    check("st_load", 32'(st_q), 32'd2);
    check("sound_load", 32'(sound_on), 32'd1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    check("dec1_dt", 32'(dt_q), 32'd2);
    check("dec1_st", 32'(st_q), 32'd1);
    check("dec1_sound", 32'(sound_on), 32'd1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    check("dec2_dt", 32'(dt_q), 32'd1);
    check("dec2_st", 32'(st_q), 32'd0);
    check("dec2_sound", 32'(sound_on), 32'd0);
    cyc(0, 1, 0, 0, 0, 8'h00);
    check("dec3_dt", 32'(dt_q), 32'd0);
    check("dec3_st", 32'(st_q), 32'd0);
    cyc(0, 1, 0, 0, 0, 8'h00);
    check("dec4_dt", 32'(dt_q), 32'd0);
    check("dec4_st", 32'(st_q), 32'd0);
    check("dec4_sound", 32'(sound_on), 32'd0);

    // Write beats a coincident 60 Hz tick
    cyc(0, 0, 0, 0, 1, 8'd5);
    check("st5", 32'(st_q), 32'd5);
    cyc(0, 1, 0, 0, 1, 8'h10);
    check("wr_prio_st", 32'(st_q), 32'h10);
    check("wr_prio_sound", 32'(sound_on), 32'd1);

    // Pause with backlog 2
    cyc(0, 0, 0, 1, 0, 8'd4);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("pre_pause_req", 32'(cpu_step_req), 32'd1);
    pause = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("pause_req", 32'(cpu_step_req), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    check("pause_req_hold", 32'(cpu_step_req), 32'd0);
    check("pause_dt_hold", 32'(dt_q), 32'd4);
    check("pause_st_hold", 32'(st_q), 32'h10);
    check("pause_ovr_hold", 32'(tick_overrun), 32'd2);
    pause = 1'b0;
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("unpause_req", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("unpause_ack1", 32'(cpu_step_req), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    check("unpause_ack2", 32'(cpu_step_req), 32'd0);

    // Writes accepted while paused; ack in the pause cycle still honoured
    cyc(1, 0, 0, 0, 0, 8'h00);
    pause = 1'b1;
    cyc(0, 0, 1, 1, 0, 8'd7);
    check("pause_write_dt", 32'(dt_q), 32'd7);
    pause = 1'b0;
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("pause_ack_honoured", 32'(cpu_step_req), 32'd0);

    // Reset mid-handshake discards owed steps
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    #2;
    check("rst_mid_req", 32'(cpu_step_req), 32'd0);
    check("rst_mid_dt", 32'(dt_q), 32'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("rst_mid_after", 32'(cpu_step_req), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
